// File: rtl/sitcpxg_tx_stream_arbiter.sv
// Round-robin arbiter sharing the SiTCPXG TCP transmit port between NUM_CH streams.
// Define SITCPXG_TXARB_HDR_EN to emit a per-grant header word (channel id + sequence).
module sitcpxg_tx_stream_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 256
) (
  input  logic                  XGMII_CLOCK,
  input  logic                  RSTn,
  input  logic                  USER_SESSION_ESTABLISHED,
  input  logic                  USER_TX_AFULL,
  output logic [63:0]           USER_TX_D,
  output logic [3:0]            USER_TX_B,
  input  logic [NUM_CH-1:0]     CH_VALID,
  input  logic [64*NUM_CH-1:0]  CH_D,
  input  logic [4*NUM_CH-1:0]   CH_B,
  input  logic [NUM_CH-1:0]     CH_LAST,
  output logic [NUM_CH-1:0]     CH_READY,
  output logic [2:0]            GRANT_ID,
  output logic                  BUSY
);

  localparam int CW = $clog2(MAX_BURST + 1);

`ifdef SITCPXG_TXARB_HDR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, XFER = 2'd2} state_t;
  logic [15:0] seq [8];
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} state_t;
`endif

  state_t          state;
  logic [2:0]      rr_ptr;
  logic [CW-1:0]   cnt;
  logic            afull_q;
  logic            est_q;

  // Channel buses widened to the 8-channel maximum so a 3-bit grant indexes them exactly.
  logic [7:0]      valid_x;
  logic [7:0]      last_x;
  logic [511:0]    d_x;
  logic [31:0]     b_x;
  logic [7:0]      ready_x;

  assign valid_x = 8'(CH_VALID);
  assign last_x  = 8'(CH_LAST);
  assign d_x     = 512'(CH_D);
  assign b_x     = 32'(CH_B);
  assign ready_x = 8'b1 << GRANT_ID;

  function automatic logic [2:0] next_ch(input logic [2:0] v);
    return (v == 3'(NUM_CH - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  logic            go;
  logic            accept;
  logic            burst_end;
  logic [63:0]     g_d;
  logic [3:0]      g_raw;
  logic [3:0]      g_b;
  logic [CW-1:0]   cnt_inc;

  assign go        = est_q & ~afull_q;
  assign accept    = (state == XFER) & go & valid_x[GRANT_ID];
  assign g_d       = d_x[{GRANT_ID, 6'b0} +: 64];
  assign g_raw     = b_x[{GRANT_ID, 2'b0} +: 4];
  assign g_b       = (g_raw == 4'd0 || g_raw > 4'd8) ? 4'd8 : g_raw;
  assign cnt_inc   = cnt + CW'(1);
  assign burst_end = last_x[GRANT_ID] | (cnt_inc == CW'(MAX_BURST));

  assign CH_READY  = (state == XFER && go) ? ready_x[NUM_CH-1:0] : '0;
  assign BUSY      = (state != IDLE);

  logic            pick_found;
  logic [2:0]      pick_id;
  logic [2:0]      cand;

  // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    cand       = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_found && valid_x[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
      cand = next_ch(cand);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      GRANT_ID  <= '0;
      USER_TX_D <= '0;
      USER_TX_B <= '0;
      afull_q   <= 1'b0;
      est_q     <= 1'b0;
`ifdef SITCPXG_TXARB_HDR_EN
      // NOTE: the sequence counters are architectural state, so this small array is reset explicitly.
      for (int i = 0; i < 8; i++) seq[i] <= '0;
`endif
    end else begin
      afull_q   <= USER_TX_AFULL;
      est_q     <= USER_SESSION_ESTABLISHED;
      USER_TX_B <= 4'd0;
      case (state)
        IDLE: begin
          if (go && pick_found) begin
            GRANT_ID <= pick_id;
            cnt      <= '0;
`ifdef SITCPXG_TXARB_HDR_EN
            state    <= HDR;
`else
            state    <= XFER;
`endif
          end
        end
`ifdef SITCPXG_TXARB_HDR_EN
        HDR: begin
          if (go) begin
            USER_TX_D     <= {8'hA5, 5'b0, GRANT_ID, seq[GRANT_ID], 32'h0};
            USER_TX_B     <= 4'd8;
            seq[GRANT_ID] <= seq[GRANT_ID] + 16'd1;
            state         <= XFER;
          end
        end
`endif
        XFER: begin
          // Session loss abandons the partial burst; the channel competes again later.
          if (!est_q) begin
            state  <= IDLE;
            rr_ptr <= next_ch(GRANT_ID);
          end else if (accept) begin
            USER_TX_D <= g_d;
            USER_TX_B <= g_b;
            cnt       <= cnt_inc;
            if (burst_end) begin
              state  <= IDLE;
              rr_ptr <= next_ch(GRANT_ID);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
